// File: rtl/reg_native_pkg.sv
// rtl/reg_native_pkg.sv - shared types and constants for the reg_native_if register slice
package reg_native_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

  function automatic int timer_width(input int cycles);
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/reg_native_timeout.sv
// rtl/reg_native_timeout.sv - clear/enable counter with terminal-count flag
module reg_native_timeout #(
  parameter int WIDTH    = 8,
  parameter int TERMINAL = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic srst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [WIDTH-1:0] count;

  assign tc = (count == WIDTH'(TERMINAL));

  // Holds at the terminal value; the owner leaves WAIT on that cycle anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (srst || clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/reg_native_slice.sv
// rtl/reg_native_slice.sv - single-outstanding reg_native_if slice with ack timeout
module reg_native_slice
  import reg_native_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 64,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    TIMEOUT_CYCLES = 256,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA       = DATA_WIDTH'(DEFAULT_ERR_DATA)
) (
  input  logic                  fsm_clk,
  input  logic                  fsm_rst,
  input  logic                  global_sync_reset_in,
  input  logic                  req_vld,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  ack_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  ds_req_vld,
  output logic                  ds_wr_en,
  output logic                  ds_rd_en,
  output logic [ADDR_WIDTH-1:0] ds_addr,
  output logic [DATA_WIDTH-1:0] ds_wr_data,
  input  logic                  ds_ack_vld,
  input  logic [DATA_WIDTH-1:0] ds_rd_data,
  output logic                  timeout_err,
  output logic                  stray_ack,
  output logic [7:0]            err_cnt
);

  localparam int TW = timer_width(TIMEOUT_CYCLES);

  state_e                state, state_n;
  logic                  ds_req_vld_n, ds_wr_en_n, ds_rd_en_n;
  logic [ADDR_WIDTH-1:0] ds_addr_n;
  logic [DATA_WIDTH-1:0] ds_wr_data_n, rd_data_n, resp_data;
  logic [7:0]            err_cnt_n;
  logic                  timer_tc;

  reg_native_timeout #(
    .WIDTH    (TW),
    .TERMINAL (TIMEOUT_CYCLES - 1)
  ) u_timeout (
    .clk  (fsm_clk),
    .rst  (fsm_rst),
    .srst (global_sync_reset_in),
    .clr  (state == ST_ISSUE),
    .en   (state == ST_WAIT),
    .tc   (timer_tc)
  );

  assign resp_data   = ds_rd_en ? ds_rd_data : '0;
  assign ack_vld     = (state == ST_RESP) && !global_sync_reset_in;
  assign timeout_err = (state == ST_WAIT) && timer_tc && !ds_ack_vld && !global_sync_reset_in;
  assign stray_ack   = ds_ack_vld && ((state == ST_IDLE) || (state == ST_RESP));

  always_comb begin
    state_n      = state;
    ds_req_vld_n = 1'b0;
    ds_wr_en_n   = ds_wr_en;
    ds_rd_en_n   = ds_rd_en;
    ds_addr_n    = ds_addr;
    ds_wr_data_n = ds_wr_data;
    rd_data_n    = rd_data;
    err_cnt_n    = err_cnt;
    unique case (state)
      ST_IDLE: if (req_vld) begin
        ds_req_vld_n = 1'b1;
        ds_wr_en_n   = wr_en;
        ds_rd_en_n   = rd_en;
        ds_addr_n    = addr;
        ds_wr_data_n = wr_data;
        state_n      = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_n = ST_WAIT;
        if (ds_ack_vld) begin
          rd_data_n = resp_data;
          state_n   = ST_RESP;
        end
      end
      ST_WAIT: begin
        // An ack landing on the terminal cycle takes priority over the timeout.
        if (ds_ack_vld) begin
          rd_data_n = resp_data;
          state_n   = ST_RESP;
        end else if (timer_tc) begin
          rd_data_n = ERR_DATA;
          if (err_cnt != 8'hFF) err_cnt_n = err_cnt + 8'd1;
          state_n   = ST_RESP;
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (global_sync_reset_in) begin
      state_n      = ST_IDLE;
      ds_req_vld_n = 1'b0;
      ds_wr_en_n   = 1'b0;
      ds_rd_en_n   = 1'b0;
      ds_addr_n    = '0;
      ds_wr_data_n = '0;
      rd_data_n    = '0;
      err_cnt_n    = '0;
    end
  end

  always_ff @(posedge fsm_clk or posedge fsm_rst) begin
    if (fsm_rst) begin
      state      <= ST_IDLE;
      ds_req_vld <= 1'b0;
      ds_wr_en   <= 1'b0;
      ds_rd_en   <= 1'b0;
      ds_addr    <= '0;
      ds_wr_data <= '0;
      rd_data    <= '0;
      err_cnt    <= '0;
    end else begin
      state      <= state_n;
      ds_req_vld <= ds_req_vld_n;
      ds_wr_en   <= ds_wr_en_n;
      ds_rd_en   <= ds_rd_en_n;
      ds_addr    <= ds_addr_n;
      ds_wr_data <= ds_wr_data_n;
      rd_data    <= rd_data_n;
      err_cnt    <= err_cnt_n;
    end
  end

endmodule

// File: tb/tb_reg_native_slice.sv
// tb/tb_reg_native_slice.sv - scoreboard bench for reg_native_slice
module tb_reg_native_slice;
  localparam int AW = 64;
  localparam int DW = 32;
  localparam int T  = 16;
  localparam logic [DW-1:0] ERR = 32'hDEAD_BEEF;

  logic clk = 1'b0, rst = 1'b1, srst = 1'b0;
  logic req_vld = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wr_data = '0, ds_rd_data = '0;
  logic ds_ack_vld = 1'b0;
  logic ack_vld, ds_req_vld, ds_wr_en, ds_rd_en, timeout_err, stray_ack;
  logic [DW-1:0] rd_data, ds_wr_data;
  logic [AW-1:0] ds_addr;
  logic [7:0] err_cnt;

  reg_native_slice #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T), .ERR_DATA(ERR)) dut (
    .fsm_clk(clk), .fsm_rst(rst), .global_sync_reset_in(srst),
    .req_vld(req_vld), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data),
    .ack_vld(ack_vld), .rd_data(rd_data),
    .ds_req_vld(ds_req_vld), .ds_wr_en(ds_wr_en), .ds_rd_en(ds_rd_en),
    .ds_addr(ds_addr), .ds_wr_data(ds_wr_data),
    .ds_ack_vld(ds_ack_vld), .ds_rd_data(ds_rd_data),
    .timeout_err(timeout_err), .stray_ack(stray_ack), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [DW-1:0] data; logic [7:0] err; } resp_t;
  typedef struct { int cyc; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic wr; } dsreq_t;

  resp_t  resp_q[$];
  resp_t  stray_q[$];
  dsreq_t ds_q[$];
  int     to_q[$];

  int n_checks = 0, n_pass = 0, cyc = 0;
  bit mon_en = 1'b0;
  logic [7:0] model_err = '0;
  logic [DW-1:0] model_rd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  initial begin
    dsreq_t de;
    resp_t  re;
    int     te;
    forever begin
      @(negedge clk); #2;
      if (mon_en) begin
        if (ds_req_vld) begin
          if (ds_q.size() == 0) check("ds_req_unexpected", 64'(ds_req_vld), 64'd0);
          else begin
            de = ds_q.pop_front();
            check("ds_req_cycle", 64'(cyc), 64'(de.cyc));
            check("ds_addr", ds_addr, de.addr);
            check("ds_wr_data", 64'(ds_wr_data), 64'(de.wdata));
            check("ds_wr_en", 64'(ds_wr_en), 64'(de.wr));
            check("ds_rd_en", 64'(ds_rd_en), 64'(!de.wr));
          end
        end
        if (ack_vld) begin
          if (resp_q.size() == 0) check("ack_unexpected", 64'(ack_vld), 64'd0);
          else begin
            re = resp_q.pop_front();
            check("ack_cycle", 64'(cyc), 64'(re.cyc));
            check("rd_data", 64'(rd_data), 64'(re.data));
            check("err_cnt", 64'(err_cnt), 64'(re.err));
          end
        end
        if (timeout_err) begin
          if (to_q.size() == 0) check("timeout_unexpected", 64'(timeout_err), 64'd0);
          else begin
            te = to_q.pop_front();
            check("timeout_cycle", 64'(cyc), 64'(te));
          end
        end
        if (stray_ack) begin
          if (stray_q.size() == 0) check("stray_unexpected", 64'(stray_ack), 64'd0);
          else begin
            re = stray_q.pop_front();
            check("stray_cycle", 64'(cyc), 64'(re.cyc));
            check("stray_rd_data", 64'(rd_data), 64'(re.data));
          end
        end
      end
    end
  end

  // ack_at: cycle (relative to request cycle 0) the slave acks; 0 = never.
  // The transaction answers normally when the ack lands in cycles 1..T+1.
  task automatic txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input logic [DW-1:0] rdat, input int ack_at);
    int i;
    bit seen;
    @(negedge clk);
    ds_ack_vld = 1'b0;
    req_vld = 1'b1; wr_en = wr; rd_en = !wr; addr = a; wr_data = wd;
    ds_q.push_back('{cyc + 1, a, wd, wr});
    if (ack_at >= 1 && ack_at <= T + 1) begin
      model_rd = wr ? '0 : rdat;
      resp_q.push_back('{cyc + ack_at + 1, model_rd, model_err});
    end else begin
      model_rd = ERR;
      if (model_err != 8'hFF) model_err = model_err + 8'd1;
      to_q.push_back(cyc + 1 + T);
      resp_q.push_back('{cyc + T + 2, ERR, model_err});
      if (ack_at >= T + 2) stray_q.push_back('{cyc + ack_at, model_rd, model_err});
    end
    i = 0;
    seen = 1'b0;
    while (1) begin
      @(negedge clk);
      i++;
      req_vld = 1'b0;
      addr = {$urandom, $urandom};
      wr_data = $urandom;
      ds_ack_vld = (i == ack_at);
      ds_rd_data = (i == ack_at) ? rdat : $urandom;
      if (ack_vld) seen = 1'b1;
      if (seen && i >= ack_at) break;
      if (i > T + 8) begin
        check("txn_completes", 64'd0, 64'd1);
        break;
      end
    end
  endtask

  task automatic srst_txn(input logic [AW-1:0] a);
    @(negedge clk);
    ds_ack_vld = 1'b0;
    req_vld = 1'b1; wr_en = 1'b0; rd_en = 1'b1; addr = a; wr_data = '0;
    ds_q.push_back('{cyc + 1, a, '0, 1'b0});
    @(negedge clk); req_vld = 1'b0;
    @(negedge clk);
    @(negedge clk); srst = 1'b1;
    @(negedge clk); srst = 1'b0;
    model_err = '0;
    model_rd = '0;
    check("srst_ack_vld", 64'(ack_vld), 64'd0);
    check("srst_rd_data", 64'(rd_data), 64'd0);
    check("srst_err_cnt", 64'(err_cnt), 64'd0);
    check("srst_ds_addr", ds_addr, 64'd0);
  endtask

  initial begin
    int r;
    int aa;
    repeat (3) @(negedge clk);
    check("rst_ack_vld", 64'(ack_vld), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_ds_req_vld", 64'(ds_req_vld), 64'd0);
    check("rst_ds_addr", ds_addr, 64'd0);
    check("rst_ds_wr_data", 64'(ds_wr_data), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_timeout_err", 64'(timeout_err), 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    txn(1'b0, 64'h40, 32'h0, 32'h1234_5678, 4);
    txn(1'b1, 64'h8, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 1);
    txn(1'b0, 64'h100, 32'h0, 32'h5555_AAAA, T + 2);
    txn(1'b0, 64'h104, 32'h0, 32'h0BAD_F00D, T + 3);
    txn(1'b0, 64'h200, 32'h0, 32'hCAFE_0001, T + 1);
    srst_txn(64'h300);
    txn(1'b0, 64'h304, 32'h0, 32'h7777_1111, 2);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) aa = 0;
      else if (r == 1) aa = T + 3;
      else if (r == 2) aa = T + 1;
      else aa = $urandom_range(1, T);
      txn(1'($urandom), {$urandom, $urandom}, $urandom, $urandom, aa);
    end

    for (int n = 0; n < 300; n++) txn(1'($urandom), {$urandom, $urandom}, $urandom, $urandom, 0);
    check("err_cnt_saturated", 64'(err_cnt), 64'd255);

    repeat (4) @(negedge clk);
    check("resp_q_drained", 64'(resp_q.size()), 64'd0);
    check("ds_q_drained", 64'(ds_q.size()), 64'd0);
    check("to_q_drained", 64'(to_q.size()), 64'd0);
    check("stray_q_drained", 64'(stray_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
